// File: rtl/sequentializer_pkg.sv
// Shared types and constant helpers for the sequentializer_gen slice.
package sequentializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Ceiling division for elaboration-time sizing.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sequentializer_gen_if.sv
// AXI-Stream style bundle used for both the input and output sides of
// sequentializer_gen. Optional tuser[1:0] (SOF/EOL) exists only when
// SEQ_TUSER_EN is defined.
interface sequentializer_gen_if #(
    parameter int unsigned DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
`ifdef SEQ_TUSER_EN
    logic [1:0]        tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
`else
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
`endif
endinterface

// File: rtl/sequentializer_gen_beat_buffer.sv
// seq_beat_buffer: cur/nxt ping-pong beat storage. cur is a shift register
// presenting its lowest GRP_WIDTH slice; nxt holds one waiting beat so cur
// can refill on the same edge it empties.
module seq_beat_buffer
    import sequentializer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 256,
    parameter int unsigned GRP_WIDTH = 8,
    parameter int unsigned GPB       = 32
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load_valid,
    input  logic [IN_WIDTH-1:0]  load_data,
    input  logic                 shift,
    input  logic                 flush,
    output logic                 cur_valid,
    output logic [GRP_WIDTH-1:0] cur_group,
    output logic                 nxt_valid
);

    localparam int unsigned IW = width_of(GPB);
    localparam logic [IW-1:0] LAST_IDX = IW'(GPB - 1);

    logic [IN_WIDTH-1:0] cur_data_q, cur_data_d;
    logic [IN_WIDTH-1:0] nxt_data_q, nxt_data_d;
    logic                cur_valid_q, cur_valid_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic [IW-1:0]       grp_idx_q, grp_idx_d;
    logic                cur_free;

    // Load, shift and refill decisions for both buffers.
    always_comb begin
        cur_data_d  = cur_data_q;
        nxt_data_d  = nxt_data_q;
        cur_valid_d = cur_valid_q;
        nxt_valid_d = nxt_valid_q;
        grp_idx_d   = grp_idx_q;
        // cur is free when empty, when its last group leaves now, or when the
        // frame ends inside this beat (trailing groups are discarded).
        cur_free = !cur_valid_q || flush || (shift && (grp_idx_q == LAST_IDX));
        if (cur_free) begin
            grp_idx_d = '0;
            if (nxt_valid_q) begin
                cur_data_d  = nxt_data_q;
                cur_valid_d = 1'b1;
                nxt_valid_d = load_valid;
                if (load_valid) begin
                    nxt_data_d = load_data;
                end
            end else if (load_valid) begin
                cur_data_d  = load_data;
                cur_valid_d = 1'b1;
            end else begin
                cur_valid_d = 1'b0;
            end
        end else begin
            if (shift) begin
                cur_data_d = cur_data_q >> GRP_WIDTH;
                grp_idx_d  = grp_idx_q + IW'(1);
            end
            if (load_valid) begin
                nxt_data_d  = load_data;
                nxt_valid_d = 1'b1;
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            cur_data_q  <= '0;
            nxt_data_q  <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            grp_idx_q   <= '0;
        end else begin
            cur_data_q  <= cur_data_d;
            nxt_data_q  <= nxt_data_d;
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            grp_idx_q   <= grp_idx_d;
        end
    end

    assign cur_valid = cur_valid_q;
    assign cur_group = cur_data_q[GRP_WIDTH-1:0];
    assign nxt_valid = nxt_valid_q;

endmodule

// File: rtl/sequentializer_gen.sv
// sequentializer_gen: wide input beats to raster-order pixel groups with
// ap_start/ap_done control and frame-end tlast.
// Optional macro SEQ_TUSER_EN adds m_axis.tuser[1:0] = {EOL, SOF}.
module sequentializer_gen
    import sequentializer_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 256,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned OUT_PIXELS  = 1,
    parameter int unsigned IN_ROWS     = 20,
    parameter int unsigned IN_COLS     = 20
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             ap_start,
    output logic                             ap_ready,
    output logic                             ap_done,
    sequentializer_gen_if.slave              s_axis,
    sequentializer_gen_if.master             m_axis,
    output logic [width_of(IN_COLS)-1:0]     cnt_col,
    output logic [width_of(IN_ROWS)-1:0]     cnt_row
);

    localparam int unsigned PPB       = IN_WIDTH / PIXEL_WIDTH;
    localparam int unsigned GPB       = PPB / OUT_PIXELS;
    localparam int unsigned FRAME_PIX = IN_ROWS * IN_COLS;
    localparam int unsigned BEATS     = ceil_div(FRAME_PIX, PPB);
    localparam int unsigned GROUPS    = FRAME_PIX / OUT_PIXELS;
    localparam int unsigned GW        = OUT_PIXELS * PIXEL_WIDTH;
    localparam int unsigned CW        = width_of(IN_COLS);
    localparam int unsigned RW        = width_of(IN_ROWS);
    localparam int unsigned GCW       = width_of(GROUPS);
    localparam int unsigned BW        = width_of(BEATS + 1);

    localparam logic [GCW-1:0] LAST_GRP  = GCW'(GROUPS - 1);
    localparam logic [CW-1:0]  LAST_COL  = CW'(IN_COLS - OUT_PIXELS);
    localparam logic [BW-1:0]  BEATS_MAX = BW'(BEATS);

    seq_state_e      state_q, state_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [GCW-1:0]  grp_cnt_q, grp_cnt_d;
    logic [CW-1:0]   cnt_col_q, cnt_col_d;
    logic [RW-1:0]   cnt_row_q, cnt_row_d;

    logic            cur_valid;
    logic            nxt_valid;
    logic [GW-1:0]   cur_group;
    logic            in_ready;
    logic            s_hs;
    logic            m_hs;
    logic            frame_last;
    logic            last_hs;

    assign in_ready   = (state_q == RUN) && !nxt_valid && (beats_q < BEATS_MAX);
    assign s_hs       = s_axis.tvalid && in_ready;
    assign m_hs       = cur_valid && m_axis.tready;
    assign frame_last = cur_valid && (grp_cnt_q == LAST_GRP);
    assign last_hs    = m_hs && frame_last;

    seq_beat_buffer #(
        .IN_WIDTH  (IN_WIDTH),
        .GRP_WIDTH (GW),
        .GPB       (GPB)
    ) u_buf (
        .clk        (clk),
        .srst       (srst),
        .load_valid (s_hs),
        .load_data  (s_axis.tdata),
        .shift      (m_hs),
        .flush      (last_hs),
        .cur_valid  (cur_valid),
        .cur_group  (cur_group),
        .nxt_valid  (nxt_valid)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start in IDLE, finish on the frame-last handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ap_start) state_d = RUN;
            RUN:     if (last_hs)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and stream outputs.
    always_comb begin
        ap_ready      = (state_q == IDLE);
        ap_done       = (state_q == DONE);
        s_axis.tready = in_ready;
        m_axis.tvalid = cur_valid;
        m_axis.tdata  = cur_group;
        m_axis.tlast  = frame_last;
`ifdef SEQ_TUSER_EN
        m_axis.tuser  = {cur_valid && (cnt_col_q == LAST_COL),
                         cur_valid && (grp_cnt_q == '0)};
`endif
        cnt_col       = cnt_col_q;
        cnt_row       = cnt_row_q;
    end

    // Beat and raster position counters.
    always_comb begin
        beats_d   = beats_q;
        grp_cnt_d = grp_cnt_q;
        cnt_col_d = cnt_col_q;
        cnt_row_d = cnt_row_q;
        if ((state_q == IDLE) && ap_start) begin
            beats_d = '0;
        end else if (s_hs) begin
            beats_d = beats_q + BW'(1);
        end
        if (m_hs) begin
            if (frame_last) begin
                grp_cnt_d = '0;
                cnt_col_d = '0;
                cnt_row_d = '0;
            end else begin
                grp_cnt_d = grp_cnt_q + GCW'(1);
                if (cnt_col_q == LAST_COL) begin
                    cnt_col_d = '0;
                    cnt_row_d = cnt_row_q + RW'(1);
                end else begin
                    cnt_col_d = cnt_col_q + CW'(OUT_PIXELS);
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            beats_q   <= '0;
            grp_cnt_q <= '0;
            cnt_col_q <= '0;
            cnt_row_q <= '0;
        end else begin
            beats_q   <= beats_d;
            grp_cnt_q <= grp_cnt_d;
            cnt_col_q <= cnt_col_d;
            cnt_row_q <= cnt_row_d;
        end
    end

endmodule

// File: tb/tb_sequentializer_gen.sv
// Directed bench for sequentializer_gen: a default 20x20 Mono8 instance and a
// 16-bit, 4-pixel-per-group 8x8 instance. SEQ_TUSER_EN adds SOF/EOL checks.
module tb_sequentializer_gen;

    logic clk = 1'b0;
    logic srst;
    int   n_err = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic       a_start, a_ready, a_done;
    logic [4:0] a_col, a_row;
    sequentializer_gen_if #(.DATA_W(256)) a_s ();
    sequentializer_gen_if #(.DATA_W(8))   a_m ();

    sequentializer_gen #(
        .IN_WIDTH(256), .PIXEL_WIDTH(8), .OUT_PIXELS(1), .IN_ROWS(20), .IN_COLS(20)
    ) dut_a (
        .clk(clk), .srst(srst), .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done),
        .s_axis(a_s), .m_axis(a_m), .cnt_col(a_col), .cnt_row(a_row)
    );

    // Instance B: 16-bit pixels, 4 per group, 8x8
    logic       b_start, b_ready, b_done;
    logic [2:0] b_col, b_row;
    sequentializer_gen_if #(.DATA_W(256)) b_s ();
    sequentializer_gen_if #(.DATA_W(64))  b_m ();

    sequentializer_gen #(
        .IN_WIDTH(256), .PIXEL_WIDTH(16), .OUT_PIXELS(4), .IN_ROWS(8), .IN_COLS(8)
    ) dut_b (
        .clk(clk), .srst(srst), .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done),
        .s_axis(b_s), .m_axis(b_m), .cnt_col(b_col), .cnt_row(b_row)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat b of instance A: byte k = (32*b + k) mod 256
    function automatic logic [255:0] beat_a(input int b);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[k*8 +: 8] = 8'((b * 32 + k) % 256);
        return v;
    endfunction

    function automatic logic [15:0] pix_b(input int p);
        return 16'(16'h1000 + p * 3);
    endfunction

    function automatic logic [255:0] beat_b(input int b);
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = pix_b(b * 16 + k);
        return v;
    endfunction

    function automatic logic [63:0] grp_b(input int g);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = pix_b(4 * g + j);
        return v;
    endfunction

    // One frame on instance A; vp/rp are source-valid / sink-ready percentages.
    // With do_abort the task returns right after 150 outputs.
    task automatic frame_a(input int vp, input int rp, input bit do_abort);
        int beat = 0;
        int outn = 0;
        int cyc = 0;
        bit took;
        bit stalled = 0;
        logic [7:0] h_d;
        logic       h_l;
        logic [4:0] h_c, h_r;
        check("a_ready_idle", a_ready, 1);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check("a_ready_run", a_ready, 0);
        while (outn < 400 && cyc < 4000) begin
            if (do_abort && outn == 150) break;
            cyc++;
            if (!a_s.tvalid && beat < 13 && int'($urandom_range(0, 99)) < vp) begin
                a_s.tvalid = 1'b1;
                a_s.tdata  = beat_a(beat);
            end
            a_m.tready = (int'($urandom_range(0, 99)) < rp);
            @(negedge clk);
            took = a_s.tvalid && a_s.tready;
            if (stalled) begin
                check("a_hold_valid", a_m.tvalid, 1);
                check("a_hold_data", a_m.tdata, h_d);
                check("a_hold_last", a_m.tlast, h_l);
                check("a_hold_col", a_col, h_c);
                check("a_hold_row", a_row, h_r);
            end
            if (vp == 100 && rp == 100 && outn > 0)
                check("a_no_gap", a_m.tvalid, 1);
            stalled = 0;
            if (a_m.tvalid) begin
                if (a_m.tready) begin
                    check("a_data", a_m.tdata, outn % 256);
                    check("a_last", a_m.tlast, outn == 399);
                    check("a_col", a_col, outn % 20);
                    check("a_row", a_row, outn / 20);
`ifdef SEQ_TUSER_EN
                    check("a_tuser", a_m.tuser, {outn % 20 == 19, outn == 0});
`endif
                    outn++;
                end else begin
                    stalled = 1;
                    h_d = a_m.tdata; h_l = a_m.tlast; h_c = a_col; h_r = a_row;
                end
            end
            @(posedge clk); #1;
            if (took) begin
                beat++;
                a_s.tvalid = 1'b0;
            end
        end
        if (do_abort) begin
            check("a_abort_point", outn, 150);
            return;
        end
        a_m.tready = 1'b0;
        check("a_outputs", outn, 400);
        check("a_beats", beat, 13);
        check("a_done_pulse", a_done, 1);
        check("a_valid_after", a_m.tvalid, 0);
        @(posedge clk); #1;
        check("a_done_clear", a_done, 0);
        check("a_ready_back", a_ready, 1);
    endtask

    // One full-rate frame on instance B.
    task automatic frame_b();
        int beat = 0;
        int g = 0;
        int cyc = 0;
        bit took;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_m.tready = 1'b1;
        while (g < 16 && cyc < 200) begin
            cyc++;
            if (!b_s.tvalid && beat < 4) begin
                b_s.tvalid = 1'b1;
                b_s.tdata  = beat_b(beat);
            end
            @(negedge clk);
            took = b_s.tvalid && b_s.tready;
            if (b_m.tvalid) begin
                check("b_data", b_m.tdata, grp_b(g));
                check("b_col", b_col, (g % 2) * 4);
                check("b_row", b_row, g / 2);
                check("b_last", b_m.tlast, g == 15);
                g++;
            end
            @(posedge clk); #1;
            if (took) begin
                beat++;
                b_s.tvalid = 1'b0;
            end
        end
        b_m.tready = 1'b0;
        check("b_groups", g, 16);
        check("b_beats", beat, 4);
        check("b_done_pulse", b_done, 1);
        @(posedge clk); #1;
        check("b_done_clear", b_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0; a_m.tready = 1'b0;
        b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tlast = 1'b0; b_m.tready = 1'b0;
`ifdef SEQ_TUSER_EN
        a_s.tuser = '0;
        b_s.tuser = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        // Reset state
        check("rst_ready", a_ready, 1);
        check("rst_done", a_done, 0);
        check("rst_mvalid", a_m.tvalid, 0);
        check("rst_sready", a_s.tready, 0);
        check("rst_last", a_m.tlast, 0);
        check("rst_col", a_col, 0);
        check("rst_row", a_row, 0);
`ifdef SEQ_TUSER_EN
        check("rst_tuser", a_m.tuser, 0);
`endif

        // Full rate, then random valid/ready
        frame_a(100, 100, 0);
        frame_a(60, 50, 0);

        // Extra beat offered while idle must not be consumed
        a_s.tvalid = 1'b1;
        a_s.tdata  = beat_a(0);
        repeat (5) begin
            @(negedge clk);
            check("idle_sready", a_s.tready, 0);
            check("idle_mvalid", a_m.tvalid, 0);
        end
        @(posedge clk); #1;
        frame_a(70, 50, 0);

        // Mid-frame reset at output 150, then a clean frame
        frame_a(100, 100, 1);
        srst = 1'b1;
        a_s.tvalid = 1'b0;
        a_m.tready = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_mvalid", a_m.tvalid, 0);
        check("mid_rst_sready", a_s.tready, 0);
        check("mid_rst_last", a_m.tlast, 0);
        check("mid_rst_done", a_done, 0);
        check("mid_rst_ready", a_ready, 1);
        check("mid_rst_col", a_col, 0);
        check("mid_rst_row", a_row, 0);
        srst = 1'b0;
        frame_a(100, 100, 0);

        // Wide pixels, multi-pixel groups
        frame_b();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
